risc_v_sequencer: RTL and testbench
===================================

Name: risc_v_sequencer

Overview:
Multi-cycle instruction sequencer for the RISC-V integer datapath. It fetches each instruction from instruction memory over a req/ready handshake and holds it in an instruction register (IR). It then decodes OP-IMM and OP instructions into the team's ALU control encoding and steps the datapath through FETCH/DECODE/EXECUTE/WRITEBACK. It owns the PC and the register-file write strobe; any unsupported opcode sends it to a sticky trap.

Parameters:
WORD_LENGTH, 32, width of PC, instruction memory address and instruction data
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, PC increment per retired instruction

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request; held high until imem_ready is seen
imem_addr  output  WORD_LENGTH  fetch address; equals pc
imem_ready  input  1  fetch data valid this cycle
imem_rdata  input  WORD_LENGTH  fetched instruction
stall  input  1  datapath hold request; sampled in EXECUTE only
instr  output  WORD_LENGTH  IR contents (rs1/rs2/rd/imm fields for the datapath)
pc  output  WORD_LENGTH  current program counter
alu_op  output  4  registered ALU operation select
cin  output  1  ALU carry-in (1 = subtract)
is_I_type  output  1  1 = immediate operand B
reg_write_en  output  1  register-file write strobe
retired  output  1  one-cycle pulse per retired instruction
illegal  output  1  sticky illegal-opcode flag

Behaviour:
- Reset (asynchronous, dominates every other input): state IDLE, pc=RESET_PC, instr=32'h00000013 (NOP), alu_op=0, cin=0, is_I_type=0, reg_write_en=0, imem_req=0, retired=0, illegal=0.
- IDLE: one cycle, then FETCH unconditionally.
- FETCH: imem_req=1, imem_addr=pc, both stable while waiting. When imem_ready=1, instr<=imem_rdata and next state is DECODE. imem_rdata is ignored when imem_ready=0.
- DECODE: fields are opcode=instr[6:0], funct3=instr[14:12], f7=instr[30]. alu_op, cin and is_I_type are registered for EXECUTE.
- Decode, opcode 0010011 (OP-IMM): is_I_type=1, cin=0.
  - funct3 000/001/010/011/100/111/110 give alu_op 0/1/2/3/4/7/8; f7 is ignored.
  - funct3 101 gives alu_op 5 when f7=0 and 6 when f7=1.
- Decode, opcode 0110011 (OP): is_I_type=0.
  - Same funct3 map as OP-IMM.
  - For funct3 000: f7=0 gives cin=0; f7=1 gives alu_op 0 with cin=1.
  - cin=0 in every other case.
- Only instr[30] of funct7 is examined. cin is never left holding a previous value.
- Any other opcode: next state is TRAP, illegal<=1, alu_op=0, cin=0, is_I_type=0.
- EXECUTE: ALU controls stay stable. While stall=1, remain in EXECUTE. When stall=0, go to WRITEBACK.
- WRITEBACK: exactly one cycle.
  - reg_write_en=1 and retired=1.
  - pc <= pc+PC_STEP, modulo 2^WORD_LENGTH (wraps to 0 at the top).
  - Next state is FETCH.
  - stall is ignored in this state.
- reg_write_en and retired are 0 in every state except WRITEBACK.
- TRAP: terminal state. imem_req=0, reg_write_en=0, pc frozen, illegal held at 1; only reset exits.
- Minimum latency: 4 cycles from FETCH entry to the retired pulse (imem_ready in the first FETCH cycle, no stall). Steady-state throughput is 1 instruction per 4 cycles.
- Reset mid-fetch: imem_req drops asynchronously and the pending response is discarded. A late imem_ready is ignored in IDLE.
- Reset and imem_ready asserted together: reset wins, and instr returns to NOP.

Decomposition:
- Shared package risc_v_pkg holds:
  - opcode constants OPC_OP_IMM=7'b0010011, OPC_OP=7'b0110011;
  - the alu_op encoding ALU_ADD=0, ALU_SLL=1, ALU_SLT=2, ALU_SLTU=3, ALU_XOR=4, ALU_SRL=5, ALU_SRA=6, ALU_AND=7, ALU_OR=8;
  - the NOP constant 32'h00000013;
  - the sequencer state enum (IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, TRAP).
- One combinational sub-module, risc_v_decode (instr in; alu_op, cin, is_I_type, legal out), is instantiated inside the sequencer and registered in DECODE.

Test Plan:
- Reset release, imem_ready tied 1, imem_rdata=32'h00500093 (addi x1,x0,5) → imem_addr=0 in FETCH. alu_op=0, is_I_type=1, cin=0 from EXECUTE. reg_write_en and retired high exactly one cycle, 4 cycles after FETCH entry. pc=4 afterwards.
- R-type sub 32'h40208033, then sra 32'h4020D033, then srl 32'h0020D033 → (alu_op 0, cin 1), (6, 0), (5, 0). is_I_type=0 for all three, pc steps 0→4→8→12.
- imem_ready held low 5 cycles → imem_req=1 and imem_addr constant throughout. No reg_write_en until 4 cycles after ready.
- stall=1 for 3 cycles in EXECUTE → controls stable. reg_write_en rises the cycle after stall falls, single pulse.
- Illegal opcode 32'h00000003 → illegal=1 from the cycle after DECODE. reg_write_en never asserts, pc frozen, imem_req=0. Reset clears illegal and pc returns to RESET_PC.
- pc preset near wrap (RESET_PC=32'hFFFFFFFC), one ADDI retired → pc=0. Asynchronous reset pulsed mid-FETCH → all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/risc_v_pkg.sv
//------------------------------------------------------------------------------
// Module   : risc_v_pkg
// Brief    : Shared opcodes, ALU control encoding and sequencer states.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package risc_v_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLL  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SRA  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } seq_state_t;

  // funct3 map shared by OP and OP-IMM; f7 only splits the right shifts.
  function automatic logic [3:0] funct3_to_alu(input logic [2:0] funct3, input logic f7);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/risc_v_decode.sv
//------------------------------------------------------------------------------
// Module   : risc_v_decode
// Brief    : Combinational OP / OP-IMM decoder into ALU control signals.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module risc_v_decode
  import risc_v_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic        cin,
  output logic        is_I_type,
  output logic        legal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_f7;
  logic       w_unused;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_f7     = instr[30];
  assign w_unused = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    alu_op    = ALU_ADD;
    cin       = 1'b0;
    is_I_type = 1'b0;
    legal     = 1'b0;
    case (w_opcode)
      OPC_OP_IMM: begin
        legal     = 1'b1;
        is_I_type = 1'b1;
        alu_op    = funct3_to_alu(w_funct3, w_f7);
      end
      OPC_OP: begin
        legal  = 1'b1;
        alu_op = funct3_to_alu(w_funct3, w_f7);
        // SUB is ADD with carry-in set
        cin    = (w_funct3 == 3'b000) && w_f7;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/risc_v_sequencer.sv
//------------------------------------------------------------------------------
// Module   : risc_v_sequencer
// Brief    : Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer with PC,
//            instruction register, registered ALU controls and sticky trap.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module risc_v_sequencer
  import risc_v_pkg::*;
#(
  parameter int unsigned                WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0]     RESET_PC    = '0,
  parameter logic [WORD_LENGTH-1:0]     PC_STEP     = WORD_LENGTH'(4)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [WORD_LENGTH-1:0] imem_addr,
  input  logic                   imem_ready,
  input  logic [WORD_LENGTH-1:0] imem_rdata,
  input  logic                   stall,
  output logic [WORD_LENGTH-1:0] instr,
  output logic [WORD_LENGTH-1:0] pc,
  output logic [3:0]             alu_op,
  output logic                   cin,
  output logic                   is_I_type,
  output logic                   reg_write_en,
  output logic                   retired,
  output logic                   illegal
);

  seq_state_t             r_state;
  seq_state_t             w_next_state;
  logic [WORD_LENGTH-1:0] r_pc;
  logic [WORD_LENGTH-1:0] r_instr;
  logic [3:0]             r_alu_op;
  logic                   r_cin;
  logic                   r_is_i_type;
  logic                   r_illegal;
  logic                   w_imem_req;
  logic                   w_writeback;

  logic [3:0]             w_dec_alu_op;
  logic                   w_dec_cin;
  logic                   w_dec_is_i_type;
  logic                   w_dec_legal;

  risc_v_decode u_decode (
    .instr     (r_instr[31:0]),
    .alu_op    (w_dec_alu_op),
    .cin       (w_dec_cin),
    .is_I_type (w_dec_is_i_type),
    .legal     (w_dec_legal)
  );

  always_comb begin
    w_next_state = r_state;
    w_imem_req   = 1'b0;
    w_writeback  = 1'b0;
    case (r_state)
      IDLE:      w_next_state = FETCH;
      FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ready) w_next_state = DECODE;
      end
      DECODE:    w_next_state = w_dec_legal ? EXECUTE : TRAP;
      EXECUTE:   if (!stall) w_next_state = WRITEBACK;
      WRITEBACK: begin
        w_writeback  = 1'b1;
        w_next_state = FETCH;
      end
      TRAP:      w_next_state = TRAP;
      default:   w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_instr     <= WORD_LENGTH'(NOP);
      r_alu_op    <= ALU_ADD;
      r_cin       <= 1'b0;
      r_is_i_type <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == FETCH && imem_ready) begin
        r_instr <= imem_rdata;
      end
      // Decoder drives zeros for illegal opcodes, so the trap path clears controls too
      if (r_state == DECODE) begin
        r_alu_op    <= w_dec_alu_op;
        r_cin       <= w_dec_cin;
        r_is_i_type <= w_dec_is_i_type;
        if (!w_dec_legal) r_illegal <= 1'b1;
      end
      if (r_state == WRITEBACK) begin
        r_pc <= r_pc + PC_STEP;
      end
    end
  end

  assign imem_req     = w_imem_req;
  assign imem_addr    = r_pc;
  assign instr        = r_instr;
  assign pc           = r_pc;
  assign alu_op       = r_alu_op;
  assign cin          = r_cin;
  assign is_I_type    = r_is_i_type;
  assign reg_write_en = w_writeback;
  assign retired      = w_writeback;
  assign illegal      = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_risc_v_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_risc_v_sequencer
// Brief    : Directed self-checking bench for risc_v_sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_risc_v_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [3:0]  alu_op;
  logic        cin;
  logic        is_I_type;
  logic        reg_write_en;
  logic        retired;
  logic        illegal;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [3:0]  w_alu_op;
  logic        w_cin;
  logic        w_is_I_type;
  logic        w_reg_write_en;
  logic        w_retired;
  logic        w_illegal;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic        cin;
    logic        is_i;
    logic [31:0] pc_next;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  risc_v_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .instr        (instr),
    .pc           (pc),
    .alu_op       (alu_op),
    .cin          (cin),
    .is_I_type    (is_I_type),
    .reg_write_en (reg_write_en),
    .retired      (retired),
    .illegal      (illegal)
  );

  // Same stimulus, PC preset just below the wrap point
  risc_v_sequencer #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (w_imem_req),
    .imem_addr    (w_imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .instr        (w_instr),
    .pc           (w_pc),
    .alu_op       (w_alu_op),
    .cin          (w_cin),
    .is_I_type    (w_is_I_type),
    .reg_write_en (w_reg_write_en),
    .retired      (w_retired),
    .illegal      (w_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"},    pc, 32'h0);
    check({tag, "_instr"}, instr, 32'h00000013);
    check({tag, "_alu"},   alu_op, 4'd0);
    check({tag, "_cin"},   cin, 1'b0);
    check({tag, "_isi"},   is_I_type, 1'b0);
    check({tag, "_we"},    reg_write_en, 1'b0);
    check({tag, "_req"},   imem_req, 1'b0);
    check({tag, "_ret"},   retired, 1'b0);
    check({tag, "_ill"},   illegal, 1'b0);
    check({tag, "_wpc"},   w_pc, 32'hFFFFFFFC);
  endtask

  // Entered with the DUT in FETCH; leaves it in the following FETCH.
  task automatic run_instr(input logic [31:0] ins, input int ready_delay, input int stall_cycles,
                           input logic [3:0] e_alu, input logic e_cin, input logic e_isi);
    exp_t e;
    exp_t got;
    e.alu_op  = e_alu;
    e.cin     = e_cin;
    e.is_i    = e_isi;
    e.pc_next = model_pc + 32'd4;
    sb_q.push_back(e);

    check("fetch_req",  imem_req, 1'b1);
    check("fetch_addr", imem_addr, model_pc);
    imem_ready = 1'b0;
    imem_rdata = 32'h00000003;
    for (int i = 0; i < ready_delay; i++) begin
      tick();
      check("wait_req",  imem_req, 1'b1);
      check("wait_addr", imem_addr, model_pc);
      check("wait_we",   reg_write_en, 1'b0);
    end
    imem_ready = 1'b1;
    imem_rdata = ins;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    check("dec_ir",  instr, ins);
    check("dec_we",  reg_write_en, 1'b0);
    check("dec_req", imem_req, 1'b0);
    stall = (stall_cycles > 0);
    tick();
    check("ex_alu", alu_op, e_alu);
    check("ex_cin", cin, e_cin);
    check("ex_isi", is_I_type, e_isi);
    check("ex_we",  reg_write_en, 1'b0);
    for (int i = 0; i < stall_cycles; i++) begin
      tick();
      check("stall_alu", alu_op, e_alu);
      check("stall_cin", cin, e_cin);
      check("stall_isi", is_I_type, e_isi);
      check("stall_we",  reg_write_en, 1'b0);
      check("stall_ret", retired, 1'b0);
    end
    stall = 1'b0;
    tick();
    check("wb_we",  reg_write_en, 1'b1);
    check("wb_ret", retired, 1'b1);
    check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    got = (sb_q.size() != 0) ? sb_q.pop_front() : e;
    check("wb_alu", alu_op, got.alu_op);
    check("wb_cin", cin, got.cin);
    check("wb_isi", is_I_type, got.is_i);
    // stall must not extend WRITEBACK
    stall = (stall_cycles > 0);
    tick();
    stall = 1'b0;
    check("post_we",  reg_write_en, 1'b0);
    check("post_ret", retired, 1'b0);
    check("post_req", imem_req, 1'b1);
    check("post_pc",  pc, got.pc_next);
    model_pc = got.pc_next;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    model_pc   = 32'h0;
    #1 reset = 1'b1;
    #1;
    check_reset_values("rst");
    tick();
    tick();
    reset = 1'b0;
    check("idle_req", imem_req, 1'b0);
    tick();
    check("fetch_ir_nop", instr, 32'h00000013);

    // addi; wrap instance must roll over to 0
    run_instr(32'h00500093, 0, 0, 4'd0, 1'b0, 1'b1);
    check("wrap_pc", w_pc, 32'h0);

    run_instr(32'h40208033, 0, 0, 4'd0, 1'b1, 1'b0);  // sub
    run_instr(32'h4020D033, 0, 0, 4'd6, 1'b0, 1'b0);  // sra
    run_instr(32'h0020D033, 0, 0, 4'd5, 1'b0, 1'b0);  // srl
    run_instr(32'h0020E033, 0, 0, 4'd8, 1'b0, 1'b0);  // or
    run_instr(32'h0FF0F093, 0, 0, 4'd7, 1'b0, 1'b1);  // andi
    run_instr(32'h4010D093, 0, 0, 4'd6, 1'b0, 1'b1);  // srai
    run_instr(32'h40000093, 0, 0, 4'd0, 1'b0, 1'b1);  // addi with bit30 set
    run_instr(32'h00500093, 5, 0, 4'd0, 1'b0, 1'b1);  // slow fetch
    run_instr(32'h40208033, 0, 3, 4'd0, 1'b1, 1'b0);  // stalled sub

    // Illegal opcode -> sticky trap
    imem_ready = 1'b1;
    imem_rdata = 32'h00000003;
    tick();
    check("ill_dec_flag", illegal, 1'b0);
    tick();
    check("trap_ill", illegal, 1'b1);
    check("trap_req", imem_req, 1'b0);
    check("trap_alu", alu_op, 4'd0);
    check("trap_isi", is_I_type, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("trap_pc",   pc, model_pc);
      check("trap_we",   reg_write_en, 1'b0);
      check("trap_hold", illegal, 1'b1);
      check("trap_req2", imem_req, 1'b0);
    end

    // Reset while imem_ready is high, then late ready during IDLE
    imem_rdata = 32'h00500093;
    reset = 1'b1;
    #1;
    check("trap_rst_ill", illegal, 1'b0);
    check("trap_rst_pc",  pc, 32'h0);
    tick();
    check("rst_ready_ir", instr, 32'h00000013);
    reset = 1'b0;
    tick();
    check("late_ready_ir", instr, 32'h00000013);
    model_pc = 32'h0;
    run_instr(32'h00500093, 0, 0, 4'd0, 1'b0, 1'b1);

    // Asynchronous reset mid-fetch
    imem_ready = 1'b0;
    tick();
    tick();
    check("mid_fetch_req", imem_req, 1'b1);
    #3 reset = 1'b1;
    #1;
    check_reset_values("async");
    tick();
    reset = 1'b0;
    tick();
    model_pc = 32'h0;
    run_instr(32'h0020D033, 0, 0, 4'd5, 1'b0, 1'b0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
